// File: rtl/instr_ram_arbiter.sv
// Instruction RAM arbiter: shares one single-port instruction memory between
// the core fetch port (p0) and a bus/debug port (p1). p1 has default priority;
// a bounded starvation counter guarantees p0 forward progress. Responses are
// routed back one cycle after the grant using a registered owner flag.
//
// owner state table
//   state    | meaning
//   OWN_NONE | no access issued last cycle, no response this cycle
//   OWN_P0   | p0 was granted last cycle, p0 response this cycle
//   OWN_P1   | p1 was granted last cycle, p1 response this cycle
module instr_ram_arbiter #(
  parameter int ADDR_WIDTH   = 17,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  p0_req_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  output logic                  p0_gnt_o,
  output logic                  p0_rvalid_o,
  output logic [31:0]           p0_rdata_o,

  input  logic                  p1_req_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic                  p1_we_i,
  input  logic [3:0]            p1_be_i,
  input  logic [31:0]           p1_wdata_i,
  output logic                  p1_gnt_o,
  output logic                  p1_rvalid_o,
  output logic [31:0]           p1_rdata_o,

  output logic                  mem_en_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic [31:0]           mem_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       starved;
  logic       p0_wins;
  owner_e     owner_q;
  owner_e     owner_d;

  assign starved = (starve_cnt == LIMIT);

  // p0 wins when it is alone or has been denied STARVE_LIMIT times in a row
  always_comb begin
    p0_wins  = p0_req_i & (~p1_req_i | starved);
    p0_gnt_o = rst_n & p0_wins;
    p1_gnt_o = rst_n & p1_req_i & ~p0_wins;
    mem_en_o = p0_gnt_o | p1_gnt_o;
  end

  // Memory request mux; all fields are zero when idle so the bus is quiet
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = 32'h0;
    if (p0_gnt_o) begin
      mem_addr_o  = p0_addr_i;
      mem_we_o    = 1'b0;
      mem_be_o    = 4'hF;
      mem_wdata_o = 32'h0;
    end else if (p1_gnt_o) begin
      mem_addr_o  = p1_addr_i;
      mem_we_o    = p1_we_i;
      mem_be_o    = p1_be_i;
      mem_wdata_o = p1_wdata_i;
    end
  end

  // Starvation counter: counts consecutive denied p0 cycles, saturates at the limit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (!p0_req_i || p0_gnt_o) begin
      starve_cnt <= 4'd0;
    end else if (!starved) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Owner state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  // Owner next state: follows whichever port was granted this cycle
  always_comb begin
    owner_d = OWN_NONE;
    if (p0_gnt_o) begin
      owner_d = OWN_P0;
    end else if (p1_gnt_o) begin
      owner_d = OWN_P1;
    end
  end

  // Response routing; reset in the response cycle kills the pending rvalid
  always_comb begin
    p0_rvalid_o = rst_n & (owner_q == OWN_P0);
    p1_rvalid_o = rst_n & (owner_q == OWN_P1);
    p0_rdata_o  = mem_rdata_i;
    p1_rdata_o  = mem_rdata_i;
  end

endmodule

// File: doc/instr_ram_arbiter.md
INSTR_RAM_ARBITER -- requirements
Module: instr_ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, SHALL set the byte-address width of all address ports.
REQ-002 Parameter STARVE_LIMIT, default 4, range 1..15, SHALL set the maximum number of consecutive denied p0 request cycles.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 p0_req_i  in  1  core instruction-fetch read request.
REQ-006 p0_addr_i  in  ADDR_WIDTH  fetch address.
REQ-007 p0_gnt_o  out  1  fetch request accepted this cycle.
REQ-008 p0_rvalid_o  out  1  fetch response valid.
REQ-009 p0_rdata_o  out  32  fetch read data.
REQ-010 p1_req_i  in  1  bus/debug request, read or write.
REQ-011 p1_addr_i  in  ADDR_WIDTH  bus address.
REQ-012 p1_we_i  in  1  1 = write.
REQ-013 p1_be_i  in  4  byte enables.
REQ-014 p1_wdata_i  in  32  write data.
REQ-015 p1_gnt_o  out  1  bus request accepted this cycle.
REQ-016 p1_rvalid_o  out  1  bus response valid (reads and writes).
REQ-017 p1_rdata_o  out  32  bus read data.
REQ-018 mem_en_o, mem_addr_o[ADDR_WIDTH], mem_we_o, mem_be_o[4], mem_wdata_o[32]  out  single-port instruction memory request.
REQ-019 mem_rdata_i  in  32  memory read data, valid the cycle after mem_en_o.

Function
REQ-020 Arbitration SHALL be combinational in the request cycle; at most one grant per cycle; mem_en_o = p0_gnt_o | p1_gnt_o.
REQ-021 Default priority: p1 SHALL win when both ports request.
REQ-022 A 4-bit starvation counter SHALL increment each cycle p0_req_i=1 and p0_gnt_o=0, and clear on any p0 grant or whenever p0_req_i=0.
REQ-023 When the counter equals STARVE_LIMIT, p0 SHALL win over p1 for that cycle; the counter never exceeds STARVE_LIMIT.
REQ-024 A lone requester SHALL be granted in the same cycle.
REQ-025 On p0 grant: mem_addr_o=p0_addr_i, mem_we_o=0, mem_be_o=4'hF, mem_wdata_o=0.
REQ-026 On p1 grant: mem_addr_o/we/be/wdata SHALL equal the p1 inputs.
REQ-027 With no grant, mem_en_o=0, mem_we_o=0, and the remaining mem outputs SHALL be 0.
REQ-028 A registered owner flag (none/p0/p1) SHALL record the granted port; the matching rvalid SHALL be 1 exactly one cycle after the grant.
REQ-029 p0_rdata_o and p1_rdata_o SHALL both be driven from mem_rdata_i; they are defined only while the corresponding rvalid=1.
REQ-030 p1 writes SHALL also produce p1_rvalid_o one cycle after the grant; p1_rdata_o is then don't-care.
REQ-031 Back-to-back grants (a grant every cycle, with the owner alternating) SHALL be supported with no bubble; throughput is 1 access/cycle.
REQ-032 Requesters SHALL hold req/address stable until granted; the arbiter SHALL NOT buffer ungranted requests.

Reset
REQ-033 While rst_n=0 at a clock edge: starvation counter=0, owner=none, p0_rvalid_o=0, p1_rvalid_o=0.
REQ-034 While rst_n=0, grants and mem_en_o SHALL be forced to 0 combinationally.
REQ-035 Reset asserted the cycle after a grant SHALL suppress that grant's rvalid.

Verification
REQ-036 Only p0 requests addr 0x100 -> p0_gnt_o=1 same cycle, mem_addr_o=0x100, mem_we_o=0; next cycle p0_rvalid_o=1, p0_rdata_o=mem_rdata_i.
REQ-037 Both request continuously, STARVE_LIMIT=4 -> p1 granted cycles 0-3, p0 granted cycle 4, p1 cycles 5-8, p0 cycle 9; the pattern repeats.
REQ-038 p1 write addr 0x40, be=4'b0011, wdata 0xDEADBEEF -> mem_we_o=1, mem_be_o=0011, mem_wdata_o=0xDEADBEEF; p1_rvalid_o=1 next cycle, p0_rvalid_o=0.
REQ-039 Alternating grants p1, p0, p1 on consecutive cycles -> rvalid toggles p1, p0, p1 one cycle later with correct rdata routing and no gap.
REQ-040 Grant p0, then rst_n=0 on the next edge -> p0_rvalid_o=0, counter=0; the first p0 request after reset is granted immediately if p1 is idle.
REQ-041 p0 denied 3 cycles, then p0_req_i drops for 1 cycle, then rises with p1 still requesting -> counter restarts at 0; p0 is next granted on the 5th denied-eligible cycle.
